bcd_to_binary: RTL

Sequential reverse double-dabble converter. It takes a packed BCD value, for example a digit string entered from the LCD/keypad side, and returns the equivalent unsigned binary value, so it is the inverse of the binary-to-BCD display path. It processes one shift or one digit correction per clock and uses a valid/ready handshake on input and a one-cycle valid pulse on output. Invalid BCD digits (greater than 9) are detected at acceptance and reported instead of converted.

---
 rtl/bcd_to_binary_pkg.sv | 16 +
 rtl/bcd_digit_check.sv | 22 ++
 rtl/bcd_to_binary.sv | 119 +++++++++++
 3 files changed

// File: rtl/bcd_to_binary_pkg.sv
// rtl/bcd_to_binary_pkg.sv - shared constants and state type for the BCD/binary converters
//   DEF_DIGITS / DEF_BIN_W : default digit count and binary width, shared with binary-to-BCD
//   state_t                : 2-bit converter state (IDLE, SHIFT, CORR, DONE_ERR)
package bcd_to_binary_pkg;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_BIN_W  = 14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    CORR     = 2'd2,
    DONE_ERR = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// rtl/bcd_digit_check.sv - flags a packed BCD word that holds any digit above 9
//   bcd : packed BCD input, digit 0 in bits [3:0]
//   bad : high when any nibble is greater than 9
module bcd_digit_check
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic                bad
);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential reverse double-dabble BCD to binary converter
//   clk, rst      : clock, asynchronous active-high reset
//   bcd_in_valid  : input strobe, taken only while ready is high
//   bcd_in        : packed BCD value, digit 0 in bits [3:0]
//   ready         : high while idle
//   bin_out       : converted value, held until the next completion
//   bin_out_valid : one-cycle pulse when bin_out / bin_err update
//   bin_err       : set with the pulse when the accepted input had a digit above 9
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bcd_in_valid,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                bin_out_valid,
  output logic                bin_err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int SC_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int DC_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_shr;
  logic [SC_W-1:0]   shift_cnt;
  logic [DC_W-1:0]   digit_cnt;
  logic              bad_digit;
  int                nib_lsb;
  logic [3:0]        cur_nib;
  logic [3:0]        fix_nib;

  bcd_digit_check #(
    .DIGITS(DIGITS)
  ) u_digit_check (
    .bcd(bcd_in),
    .bad(bad_digit)
  );

  // The zero fill from the logical shift lands in the bcd MSB, and the bcd LSB
  // drops into the bin MSB, because the two parts are one contiguous register.
  always_comb begin
    work_shr = work >> 1;
    nib_lsb  = BIN_W + 4 * int'(digit_cnt);
    cur_nib  = work[nib_lsb +: 4];
    // Undo the "+3 when >= 5" step of double-dabble: a shifted digit >= 8 had
    // been adjusted, so it loses 3 locally with no borrow into its neighbour.
    fix_nib  = (cur_nib >= 4'd8) ? (cur_nib - 4'd3) : cur_nib;
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      work          <= '0;
      shift_cnt     <= '0;
      digit_cnt     <= '0;
      bin_out       <= '0;
      bin_out_valid <= 1'b0;
      bin_err       <= 1'b0;
    end else begin
      bin_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bcd_in_valid) begin
            if (bad_digit) begin
              state <= DONE_ERR;
            end else begin
              work      <= {bcd_in, {BIN_W{1'b0}}};
              shift_cnt <= '0;
              digit_cnt <= '0;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_shr;
          if (shift_cnt == SC_W'(BIN_W - 1)) begin
            bin_out       <= work_shr[BIN_W-1:0];
            bin_err       <= 1'b0;
            bin_out_valid <= 1'b1;
            state         <= IDLE;
          end else begin
            shift_cnt <= shift_cnt + SC_W'(1);
            digit_cnt <= '0;
            state     <= CORR;
          end
        end
        CORR: begin
          work[nib_lsb +: 4] <= fix_nib;
          if (digit_cnt == DC_W'(DIGITS - 1)) begin
            digit_cnt <= '0;
            state     <= SHIFT;
          end else begin
            digit_cnt <= digit_cnt + DC_W'(1);
          end
        end
        DONE_ERR: begin
          bin_out       <= '0;
          bin_err       <= 1'b1;
          bin_out_valid <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
